// File: rtl/map_mmc3_multi_if.sv
// Cartridge-edge bus between the console side (CPU/PPU) and the MMC3 multicart mapper.
interface map_mmc3_multi_if #(
    parameter int PRG_W = 19,
    parameter int CHR_W = 19
) ();
    logic [14:0]       cpu_addr;
    logic [7:0]        cpu_dat;
    logic              cpu_rw;
    logic              cpu_ce;
    logic [3:0]        ppu_addr;
    logic [PRG_W-14:0] prg_addr;
    logic [CHR_W-11:0] chr_addr;
    logic              ciram_a10;
    logic              ciram_ce;
    logic              ram_ce;
    logic              ram_we;
    logic              irq;

    modport master (
        output cpu_addr, cpu_dat, cpu_rw, cpu_ce, ppu_addr,
        input  prg_addr, chr_addr, ciram_a10, ciram_ce, ram_ce, ram_we, irq
    );

    modport slave (
        input  cpu_addr, cpu_dat, cpu_rw, cpu_ce, ppu_addr,
        output prg_addr, chr_addr, ciram_a10, ciram_ce, ram_ce, ram_we, irq
    );
endinterface

// File: rtl/map_mmc3_multi.sv
// MMC3-compatible mapper with a lockable outer-bank register (multicart) and an
// A12-filtered scanline IRQ counter.
module map_mmc3_multi #(
    parameter int OUTER_BITS = 2,
    parameter int PRG_W      = 19,
    parameter int CHR_W      = 19,
    parameter int A12_FILT   = 3,
    parameter int IRQ_MODE   = 0,
    parameter int LOCK_EN    = 1
) (
    input  logic               m2,
    input  logic               map_rst,
    map_mmc3_multi_if.slave    bus
);
    localparam int PRG_IN = PRG_W - 13 - OUTER_BITS;
    localparam int CHR_IN = CHR_W - 10 - OUTER_BITS;

    logic [7:0]            r_bank [8];
    logic [2:0]            r_sel;
    logic                  r_prg_mode;
    logic                  r_chr_inv;
    logic                  r_mirror;
    logic                  r_wram_en;
    logic                  r_wram_wp;
    logic                  r_mmc3_mode;
    logic [1:0]            r_nrom_bank;
    logic                  r_lock;
    logic [OUTER_BITS-1:0] r_outer;
    logic [7:0]            r_latch;
    logic [7:0]            r_count;
    logic                  r_pending;
    logic                  r_irq_en;
    logic                  r_irq;
    logic [2:0]            r_lowrun;

    logic [1:0]            w_a14_13;
    logic                  w_wr;
    logic [2:0]            w_reg;
    logic                  w_locked;
    logic                  w_outer_wr;
    logic                  w_a12;
    logic                  w_rise;
    logic                  w_reload;
    logic [7:0]            w_count_nxt;
    logic                  w_set_cond;
    logic                  w_irq_set;
    logic [PRG_IN-1:0]     w_prg_inner;
    logic [7:0]            w_chr_bank;
    logic                  w_a12x;

    // Zero-extend or truncate an 8-bit bank number to the inner address width.
    function automatic logic [PRG_IN-1:0] prg_bank(input logic [7:0] b);
        prg_bank = '0;
        for (int unsigned i = 0; i < PRG_IN; i++) prg_bank[i] = (i < 8) && b[i[2:0]];
    endfunction

    function automatic logic [CHR_IN-1:0] chr_bank(input logic [7:0] b);
        chr_bank = '0;
        for (int unsigned i = 0; i < CHR_IN; i++) chr_bank[i] = (i < 8) && b[i[2:0]];
    endfunction

    assign w_a14_13   = bus.cpu_addr[14:13];
    assign w_wr       = !bus.cpu_ce && !bus.cpu_rw;
    assign w_reg      = {bus.cpu_addr[14:13], bus.cpu_addr[0]};
    assign w_locked   = (LOCK_EN != 0) && r_lock;
    assign w_outer_wr = bus.cpu_ce && !bus.cpu_rw && (w_a14_13 == 2'b11) && r_wram_en && !w_locked;

    assign w_a12       = bus.ppu_addr[2];
    assign w_rise      = w_a12 && (r_lowrun >= 3'(A12_FILT));
    assign w_reload    = (r_count == 8'd0) || r_pending;
    assign w_count_nxt = w_reload ? r_latch : r_count - 8'd1;

    // Old-style IRQ fires only on a real 1->0 step or on a forced reload of zero.
    generate
        if (IRQ_MODE == 0) begin : g_irq_new
            assign w_set_cond = (w_count_nxt == 8'd0);
        end else begin : g_irq_old
            assign w_set_cond = (r_pending && (r_latch == 8'd0)) || (!w_reload && (r_count == 8'd1));
        end
    endgenerate

    assign w_irq_set = w_rise && r_irq_en && w_set_cond;

    always_ff @(posedge m2 or posedge map_rst) begin
        if (map_rst) begin
            r_bank[0]   <= 8'd0;
            r_bank[1]   <= 8'd2;
            r_bank[2]   <= 8'd4;
            r_bank[3]   <= 8'd5;
            r_bank[4]   <= 8'd6;
            r_bank[5]   <= 8'd7;
            r_bank[6]   <= 8'd0;
            r_bank[7]   <= 8'd1;
            r_sel       <= '0;
            r_prg_mode  <= 1'b0;
            r_chr_inv   <= 1'b0;
            r_mirror    <= 1'b0;
            r_wram_en   <= 1'b0;
            r_wram_wp   <= 1'b0;
            r_mmc3_mode <= 1'b0;
            r_nrom_bank <= '0;
            r_lock      <= 1'b0;
            r_outer     <= '0;
            r_latch     <= '0;
            r_count     <= '0;
            r_pending   <= 1'b0;
            r_irq_en    <= 1'b0;
            r_irq       <= 1'b0;
            r_lowrun    <= '0;
        end else begin
            if (w_wr) begin
                case (w_reg)
                    3'd0: begin
                        r_sel      <= bus.cpu_dat[2:0];
                        r_prg_mode <= bus.cpu_dat[6];
                        r_chr_inv  <= bus.cpu_dat[7];
                    end
                    3'd1: r_bank[r_sel] <= (r_sel[2:1] == 2'b00) ? {bus.cpu_dat[7:1], 1'b0} : bus.cpu_dat;
                    3'd2: r_mirror <= bus.cpu_dat[0];
                    3'd3: begin
                        r_wram_en <= bus.cpu_dat[7];
                        r_wram_wp <= bus.cpu_dat[6];
                    end
                    3'd4: r_latch <= bus.cpu_dat;
                    3'd6: r_irq_en <= 1'b0;
                    3'd7: r_irq_en <= 1'b1;
                    default: ;
                endcase
            end

            if (w_outer_wr) begin
                r_mmc3_mode <= bus.cpu_dat[0];
                r_nrom_bank <= bus.cpu_dat[2:1];
                r_lock      <= bus.cpu_dat[3];
                r_outer     <= bus.cpu_dat[7:8-OUTER_BITS];
            end

            if (w_rise) begin
                r_count <= w_count_nxt;
                if (w_reload) r_pending <= 1'b0;
            end
            // A reload request landing on a counted rise must survive it.
            if (w_wr && (w_reg == 3'd5)) r_pending <= 1'b1;

            if (w_a12)                r_lowrun <= '0;
            else if (r_lowrun != 3'd7) r_lowrun <= r_lowrun + 3'd1;

            if (w_wr && (w_reg == 3'd6)) r_irq <= 1'b0;
            else if (w_irq_set)          r_irq <= 1'b1;
        end
    end

    always_comb begin
        w_prg_inner = '0;
        if (r_mmc3_mode) begin
            case ({r_prg_mode, w_a14_13})
                3'b000:  w_prg_inner = prg_bank(r_bank[6]);
                3'b001:  w_prg_inner = prg_bank(r_bank[7]);
                3'b010:  w_prg_inner = {{(PRG_IN-1){1'b1}}, 1'b0};
                3'b100:  w_prg_inner = {{(PRG_IN-1){1'b1}}, 1'b0};
                3'b101:  w_prg_inner = prg_bank(r_bank[7]);
                3'b110:  w_prg_inner = prg_bank(r_bank[6]);
                default: w_prg_inner = '1;
            endcase
        end else begin
            w_prg_inner = prg_bank({4'b0000, r_nrom_bank, w_a14_13});
        end
    end

    assign w_a12x = bus.ppu_addr[2] ^ r_chr_inv;

    always_comb begin
        w_chr_bank = '0;
        if (!w_a12x) w_chr_bank = {r_bank[{2'b00, bus.ppu_addr[1]}][7:1], bus.ppu_addr[0]};
        else         w_chr_bank = r_bank[{1'b0, bus.ppu_addr[1:0]} + 3'd2];
    end

    assign bus.prg_addr  = bus.cpu_ce ? '0 : {r_outer, w_prg_inner};
    assign bus.chr_addr  = {r_outer, chr_bank(w_chr_bank)};
    assign bus.ciram_a10 = r_mirror ? bus.ppu_addr[1] : bus.ppu_addr[0];
    assign bus.ciram_ce  = !bus.ppu_addr[3];
    assign bus.ram_ce    = r_wram_en && bus.cpu_ce && (w_a14_13 == 2'b11);
    assign bus.ram_we    = bus.ram_ce && !bus.cpu_rw && !r_wram_wp;
    assign bus.irq       = r_irq;
endmodule
